// File: rtl/key_dir_pkg.sv
// Shared keycodes and direction ids for the key direction filter.
// The ball block consumes the 8-bit USB codes defined here.
package key_dir_pkg;

  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    DIR_W,
    DIR_A,
    DIR_S,
    DIR_D
  } dir_id_t;

  function automatic logic [7:0] dir_code(input dir_id_t d);
    dir_code = KEY_NONE;
    unique case (d)
      DIR_W: dir_code = KEY_W;
      DIR_A: dir_code = KEY_A;
      DIR_S: dir_code = KEY_S;
      DIR_D: dir_code = KEY_D;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: stable flips after the raw level has disagreed
// for DEBOUNCE_CYCLES consecutive edges; rise/fall mark that edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          flip;

  always_comb begin
    flip     = (raw != stable_q) && (cnt_q == LAST);
    stable_d = stable_q ^ flip;
    cnt_d    = cnt_q + CW'(1);
    if ((raw == stable_q) || flip) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  assign rise   = flip & ~stable_q;
  assign fall   = flip & stable_q;

endmodule

// File: rtl/key_direction_filter.sv
// Turns raw keyboard slots into one frame-stable WASD keycode;
// the most recently pressed held key wins.
module key_direction_filter
  import key_dir_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [8*NUM_SLOTS-1:0] keycode_bus,
  input  logic                   frame_tick,
  output logic [7:0]             keycode,
  output logic [3:0]             held_mask,
  output logic                   press_pulse
);

  logic [3:0] raw_q, raw_d;
  logic [3:0] stable, rise, fall;

  dir_id_t    stk_q [4];
  dir_id_t    stk_d [4];
  logic [2:0] stk_cnt_q, stk_cnt_d;

  logic       pulse_q, pulse_d;
  logic [7:0] keycode_q, keycode_d;
  logic [7:0] cand;
  logic [1:0] top_idx;

  always_comb begin
    raw_d = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (keycode_bus[8*s +: 8] == dir_code(dir_id_t'(2'(k)))) begin
          raw_d[k] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .Clk   (Clk),
      .Reset (Reset),
      .raw   (raw_q[g]),
      .stable(stable[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  // Removals compact first, then rises push W,A,S,D so D lands on top.
  always_comb begin
    logic [2:0] n;
    logic       dup;
    n   = '0;
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stk_d[i] = DIR_W;
    end
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < stk_cnt_q) && !fall[stk_q[i]]) begin
        stk_d[n[1:0]] = stk_q[i];
        n = n + 3'd1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (rise[k]) begin
        dup = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if ((3'(j) < n) && (stk_d[j] == dir_id_t'(2'(k)))) begin
            dup = 1'b1;
          end
        end
        if (!dup && (n < 3'd4)) begin
          stk_d[n[1:0]] = dir_id_t'(2'(k));
          n = n + 3'd1;
        end
      end
    end
    stk_cnt_d = n;
  end

  always_comb begin
    top_idx   = 2'(stk_cnt_q - 3'd1);
    cand      = (stk_cnt_q == 3'd0) ? KEY_NONE
                                    : dir_code(stk_q[top_idx]);
    pulse_d   = |rise;
    keycode_d = frame_tick ? cand : keycode_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      raw_q     <= '0;
      stk_cnt_q <= '0;
      pulse_q   <= 1'b0;
      keycode_q <= KEY_NONE;
      for (int i = 0; i < 4; i++) begin
        stk_q[i] <= DIR_W;
      end
    end else begin
      raw_q     <= raw_d;
      stk_cnt_q <= stk_cnt_d;
      pulse_q   <= pulse_d;
      keycode_q <= keycode_d;
      for (int i = 0; i < 4; i++) begin
        stk_q[i] <= stk_d[i];
      end
    end
  end

  assign keycode     = keycode_q;
  assign held_mask   = stable;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_key_direction_filter.sv
// Directed bench for key_direction_filter with DEBOUNCE_CYCLES=4,
// NUM_SLOTS=4; expected values are hand-derived constants.
module tb_key_direction_filter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] keycode_bus;
  logic        frame_tick;
  logic [7:0]  keycode;
  logic [3:0]  held_mask;
  logic        press_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  key_direction_filter #(
    .NUM_SLOTS      (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_bus(keycode_bus),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .held_mask  (held_mask),
    .press_pulse(press_pulse)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int seen_held;
    int seen_pulse;
    Reset       = 1'b0;
    keycode_bus = 32'h0;
    frame_tick  = 1'b0;
    step(2);
    Reset = 1'b1;

    // Test 1: build state, then async reset mid-cycle
    keycode_bus = 32'h0000001A;
    step(5);
    chk("t1_pre_held", 32'(held_mask), 32'h1);
    tick();
    chk("t1_pre_key", 32'(keycode), 32'h1A);
    #3;
    Reset = 1'b0;
    #1;
    chk("t1_rst_key", 32'(keycode), 32'h00);
    chk("t1_rst_held", 32'(held_mask), 32'h0);
    chk("t1_rst_pulse", 32'(press_pulse), 32'h0);
    #1;
    Reset = 1'b1;
    step(4);
    chk("t1_held_e4", 32'(held_mask), 32'h0);
    step(1);
    chk("t1_held_e5", 32'(held_mask), 32'h1);
    chk("t1_pulse", 32'(press_pulse), 32'h1);
    step(1);
    chk("t1_pulse_off", 32'(press_pulse), 32'h0);
    chk("t1_key_pre", 32'(keycode), 32'h00);
    tick();
    chk("t1_key", 32'(keycode), 32'h1A);

    keycode_bus = 32'h0;
    step(5);
    tick();
    chk("t1_release", 32'(keycode), 32'h00);

    // Test 2: 3-cycle glitch on D never reaches the output
    seen_held   = 0;
    seen_pulse  = 0;
    keycode_bus = 32'h00070000;
    for (int c = 0; c < 32; c++) begin
      if (c == 3) keycode_bus = 32'h0;
      frame_tick = (c % 8 == 7);
      step(1);
      if (held_mask != 4'h0) seen_held++;
      if (press_pulse) seen_pulse++;
    end
    frame_tick = 1'b0;
    chk("t2_held", 32'(seen_held), 32'd0);
    chk("t2_pulse", 32'(seen_pulse), 32'd0);
    chk("t2_key", 32'(keycode), 32'h00);

    // Test 3: W, then D on top, then drop D, then drop W
    keycode_bus = 32'h0000001A;
    step(5);
    tick();
    chk("t3_w", 32'(keycode), 32'h1A);
    keycode_bus = 32'h0000071A;
    step(5);
    chk("t3_wd_held", 32'(held_mask), 32'h9);
    chk("t3_wd_notick", 32'(keycode), 32'h1A);
    tick();
    chk("t3_d", 32'(keycode), 32'h07);
    keycode_bus = 32'h0000001A;
    step(5);
    tick();
    chk("t3_back_w", 32'(keycode), 32'h1A);
    keycode_bus = 32'h0;
    step(5);
    tick();
    chk("t3_none", 32'(keycode), 32'h00);

    // Test 4: W and S together, S wins, single pulse
    keycode_bus = 32'h00001A16;
    step(4);
    chk("t4_held_e4", 32'(held_mask), 32'h0);
    step(1);
    chk("t4_held", 32'(held_mask), 32'h5);
    chk("t4_pulse", 32'(press_pulse), 32'h1);
    step(1);
    chk("t4_pulse_off", 32'(press_pulse), 32'h0);
    tick();
    chk("t4_s", 32'(keycode), 32'h16);
    keycode_bus = 32'h00001A00;
    step(5);
    tick();
    chk("t4_w", 32'(keycode), 32'h1A);
    keycode_bus = 32'h0;
    step(5);
    tick();
    chk("t4_none", 32'(keycode), 32'h00);

    // Test 5: press order W, D, A then release back down
    keycode_bus = 32'h0000001A;
    step(20);
    keycode_bus = 32'h0000071A;
    step(20);
    keycode_bus = 32'h0004071A;
    step(20);
    tick();
    chk("t5_a", 32'(keycode), 32'h04);
    keycode_bus = 32'h0000071A;
    step(5);
    tick();
    chk("t5_d", 32'(keycode), 32'h07);
    keycode_bus = 32'h0000001A;
    step(5);
    tick();
    chk("t5_w", 32'(keycode), 32'h1A);
    keycode_bus = 32'h0;
    bad = 0;
    repeat (50) begin
      step(1);
      if (keycode !== 8'h1A) bad++;
    end
    chk("t5_hold50", 32'(bad), 32'd0);
    chk("t5_held0", 32'(held_mask), 32'h0);
    tick();
    chk("t5_none", 32'(keycode), 32'h00);

    // Test 6: duplicate W plus foreign code
    keycode_bus = 32'h002C1A1A;
    step(5);
    chk("t6_held", 32'(held_mask), 32'h1);
    chk("t6_count", 32'(dut.stk_cnt_q), 32'd1);
    tick();
    chk("t6_key", 32'(keycode), 32'h1A);

    // Tick on the same edge as the stack update keeps the old value
    keycode_bus = 32'h0;
    step(4);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("t6_coin_held", 32'(held_mask), 32'h0);
    chk("t6_coin_key", 32'(keycode), 32'h1A);
    tick();
    chk("t6_after", 32'(keycode), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
